// File: rtl/sm3_pkg.sv
// Shared configuration and state encoding for the SM3 message padder.
package sm3_pkg;

   localparam int unsigned INPT_DW      = 32;
   localparam int unsigned INPT_BYTE_DW = INPT_DW / 8;
   localparam int unsigned BLK_WORDS    = 512 / INPT_DW;
   localparam int unsigned IDX_W        = $clog2(BLK_WORDS);
   localparam int unsigned NB_W         = $clog2(INPT_BYTE_DW) + 1;

   // The 64-bit length occupies the tail of every final block.
   localparam logic [IDX_W-1:0] LEN_IDX_FIRST = IDX_W'(BLK_WORDS - 64 / INPT_DW);
   localparam logic [IDX_W-1:0] LEN_IDX_LAST  = IDX_W'(BLK_WORDS - 1);

   typedef enum logic [1:0] {IDLE_MSG, PAD80, ZERO, LEN} pad_state_e;

endpackage

// File: rtl/sm3_pad_last_word.sv
// Merges the final message word with the 0x80 marker and zero fill; reports valid-byte count.
module sm3_pad_last_word
   import sm3_pkg::*;
(
   input  logic [INPT_DW-1:0]      d_i,
   input  logic [INPT_BYTE_DW-1:0] mask_i,
   output logic [INPT_DW-1:0]      word_o,
   output logic [NB_W-1:0]         nbytes_o
);

   always_comb begin
      nbytes_o = '0;
      for (int i = 0; i < INPT_BYTE_DW; i++) begin
         nbytes_o = nbytes_o + NB_W'(mask_i[i]);
      end
   end

   // Lanes are treated as a contiguous run from byte 0 of length popcount(mask).
   always_comb begin
      word_o = '0;
      for (int i = 0; i < INPT_BYTE_DW; i++) begin
         if (NB_W'(i) < nbytes_o) begin
            word_o[INPT_DW-1-8*i -: 8] = d_i[INPT_DW-1-8*i -: 8];
         end else if (NB_W'(i) == nbytes_o) begin
            word_o[INPT_DW-1-8*i -: 8] = 8'h80;
         end
      end
   end

endmodule

// File: rtl/sm3_msg_padder.sv
// SM3 padding front end: message words, 0x80, zero fill, 64-bit big-endian bit length.
module sm3_msg_padder
   import sm3_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [INPT_DW-1:0]      msg_inpt_d_i,
   input  logic [INPT_BYTE_DW-1:0] msg_inpt_vld_byte_i,
   input  logic                    msg_inpt_vld_i,
   input  logic                    msg_inpt_lst_i,
   input  logic                    pad_otpt_ena_i,
   output logic                    msg_inpt_rdy_o,
   output logic [INPT_DW-1:0]      pad_otpt_d_o,
   output logic                    pad_otpt_lst_o,
   output logic                    pad_otpt_vld_o
);

   pad_state_e         state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d, idx_inc;
   logic [60:0]        cnt_q, cnt_d;
   logic [INPT_DW-1:0] out_d_q, out_d_d;
   logic               out_vld_q, out_vld_d;
   logic               out_lst_q, out_lst_d;
   logic               init_q;
   logic               load, in_fire;
   logic [INPT_DW-1:0] last_word;
   logic [NB_W-1:0]    last_nb;
   logic [63:0]        bit_len, len_sh;
   pad_state_e         next_fill;

   sm3_pad_last_word u_last_word (
      .d_i      (msg_inpt_d_i),
      .mask_i   (msg_inpt_vld_byte_i),
      .word_o   (last_word),
      .nbytes_o (last_nb)
   );

   assign load           = !out_vld_q || pad_otpt_ena_i;
   // init_q keeps ready low while reset is asserted.
   assign msg_inpt_rdy_o = init_q && (state_q == IDLE_MSG) && load;
   assign in_fire        = msg_inpt_vld_i && msg_inpt_rdy_o;
   assign idx_inc        = idx_q + 1'b1;
   assign bit_len        = {cnt_q, 3'b000};
   assign len_sh         = (idx_q == LEN_IDX_LAST) ? bit_len : (bit_len >> 32);
   assign next_fill      = (idx_inc == LEN_IDX_FIRST) ? LEN : ZERO;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      out_d_d   = out_d_q;
      out_vld_d = out_vld_q;
      out_lst_d = out_lst_q;
      if (load) begin
         out_d_d   = '0;
         out_vld_d = 1'b0;
         out_lst_d = 1'b0;
         unique case (state_q)
            IDLE_MSG: begin
               if (in_fire) begin
                  out_vld_d = 1'b1;
                  idx_d     = idx_inc;
                  cnt_d     = cnt_q + 61'(last_nb);
                  if (msg_inpt_lst_i) begin
                     out_d_d = last_word;
                     state_d = (last_nb == NB_W'(INPT_BYTE_DW)) ? PAD80 : next_fill;
                  end else begin
                     out_d_d = msg_inpt_d_i;
                  end
               end
            end
            PAD80: begin
               out_vld_d = 1'b1;
               out_d_d   = {8'h80, {(INPT_DW-8){1'b0}}};
               idx_d     = idx_inc;
               state_d   = next_fill;
            end
            ZERO: begin
               out_vld_d = 1'b1;
               idx_d     = idx_inc;
               state_d   = next_fill;
            end
            LEN: begin
               out_vld_d = 1'b1;
               out_d_d   = len_sh[INPT_DW-1:0];
               if (idx_q == LEN_IDX_LAST) begin
                  out_lst_d = 1'b1;
                  state_d   = IDLE_MSG;
                  idx_d     = '0;
                  cnt_d     = '0;
               end else begin
                  idx_d = idx_inc;
               end
            end
            default: state_d = IDLE_MSG;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE_MSG;
         idx_q     <= '0;
         cnt_q     <= '0;
         out_d_q   <= '0;
         out_vld_q <= 1'b0;
         out_lst_q <= 1'b0;
         init_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         out_d_q   <= out_d_d;
         out_vld_q <= out_vld_d;
         out_lst_q <= out_lst_d;
         init_q    <= 1'b1;
      end
   end

   assign pad_otpt_d_o   = out_d_q;
   assign pad_otpt_vld_o = out_vld_q;
   assign pad_otpt_lst_o = out_lst_q;

endmodule

// File: tb/tb_sm3_msg_padder.sv
// Scoreboard bench for sm3_msg_padder against a byte-level padding reference model.
module tb_sm3_msg_padder;
   import sm3_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic [INPT_DW-1:0]      msg_inpt_d_i = '0;
   logic [INPT_BYTE_DW-1:0] msg_inpt_vld_byte_i = '0;
   logic                    msg_inpt_vld_i = 1'b0;
   logic                    msg_inpt_lst_i = 1'b0;
   logic                    pad_otpt_ena_i = 1'b1;
   logic                    msg_inpt_rdy_o;
   logic [INPT_DW-1:0]      pad_otpt_d_o;
   logic                    pad_otpt_lst_o;
   logic                    pad_otpt_vld_o;

   typedef struct packed {
      logic [INPT_DW-1:0] d;
      logic               lst;
   } exp_t;

   exp_t         exp_q[$];
   int           checks = 0;
   int           failures = 0;
   bit           rand_ena = 1'b0;
   int           stall_n = 0;
   byte unsigned msg[];

   sm3_msg_padder dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .msg_inpt_d_i        (msg_inpt_d_i),
      .msg_inpt_vld_byte_i (msg_inpt_vld_byte_i),
      .msg_inpt_vld_i      (msg_inpt_vld_i),
      .msg_inpt_lst_i      (msg_inpt_lst_i),
      .pad_otpt_ena_i      (pad_otpt_ena_i),
      .msg_inpt_rdy_o      (msg_inpt_rdy_o),
      .pad_otpt_d_o        (pad_otpt_d_o),
      .pad_otpt_lst_o      (pad_otpt_lst_o),
      .pad_otpt_vld_o      (pad_otpt_vld_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Downstream enable: forced stalls take priority, otherwise random or always-on.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (stall_n > 0) begin
            pad_otpt_ena_i = 1'b0;
            stall_n--;
         end else if (rand_ena) begin
            pad_otpt_ena_i = ($urandom_range(0, 3) != 0);
         end else begin
            pad_otpt_ena_i = 1'b1;
         end
      end
   end

   // Monitor: pops expected words on each output transfer and checks stall behaviour.
   initial begin
      exp_t               e;
      bit                 prev_stall = 1'b0;
      logic [INPT_DW-1:0] prev_d = '0;
      logic               prev_lst = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_d", 64'(pad_otpt_d_o), 64'(prev_d));
               check("hold_vld_lst", {62'd0, pad_otpt_vld_o, pad_otpt_lst_o},
                     {62'd0, 1'b1, prev_lst});
            end
            if (pad_otpt_vld_o && !pad_otpt_ena_i) begin
               check("rdy_during_stall", 64'(msg_inpt_rdy_o), 64'd0);
            end
            if (pad_otpt_vld_o && pad_otpt_ena_i) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_output: got d=%0h lst=%0b, expected no word",
                           pad_otpt_d_o, pad_otpt_lst_o);
               end else begin
                  e = exp_q.pop_front();
                  check("out_word", 64'(pad_otpt_d_o), 64'(e.d));
                  check("out_lst", 64'(pad_otpt_lst_o), 64'(e.lst));
               end
            end
            prev_stall = pad_otpt_vld_o && !pad_otpt_ena_i;
            prev_d     = pad_otpt_d_o;
            prev_lst   = pad_otpt_lst_o;
         end
      end
   end

   task automatic drive_beat(input logic [INPT_DW-1:0] d, input logic [INPT_BYTE_DW-1:0] m,
                             input logic l);
      int tries = 0;
      bit done = 1'b0;
      repeat ($urandom_range(0, 2)) begin
         msg_inpt_vld_i      = 1'b0;
         msg_inpt_d_i        = INPT_DW'($urandom);
         msg_inpt_vld_byte_i = INPT_BYTE_DW'($urandom);
         msg_inpt_lst_i      = 1'($urandom);
         @(posedge clk);
         #1;
      end
      msg_inpt_vld_i      = 1'b1;
      msg_inpt_d_i        = d;
      msg_inpt_vld_byte_i = m;
      msg_inpt_lst_i      = l;
      while (!done) begin
         @(negedge clk);
         if (msg_inpt_rdy_o) begin
            done = 1'b1;
         end else if (++tries > 2000) begin
            checks++;
            failures++;
            $display("FAIL input_accept_timeout: got no ready after %0d cycles, expected ready",
                     tries);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      msg_inpt_vld_i = 1'b0;
      msg_inpt_lst_i = 1'b0;
   endtask

   // Reference: byte list = msg, 0x80, zeros to 56 mod 64, 8-byte big-endian bit length.
   task automatic push_expected(input int len);
      byte unsigned pb[$];
      logic [63:0]  bl;
      exp_t         e;
      int           nw;
      foreach (msg[i]) pb.push_back(msg[i]);
      pb.push_back(8'h80);
      while (pb.size() % 64 != 56) pb.push_back(8'h00);
      bl = 64'(len) * 64'd8;
      for (int i = 7; i >= 0; i--) pb.push_back(bl[8*i +: 8]);
      nw = pb.size() / INPT_BYTE_DW;
      for (int w = 0; w < nw; w++) begin
         e.d = '0;
         for (int b = 0; b < INPT_BYTE_DW; b++) begin
            e.d = (e.d << 8) | INPT_DW'(pb[w*INPT_BYTE_DW+b]);
         end
         e.lst = (w == nw - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic send_msg(input int len, input bit abc, input bit zero_tail);
      int                      full, rem;
      logic [INPT_DW-1:0]      w;
      logic [INPT_BYTE_DW-1:0] m;
      msg = new[len];
      for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
      if (abc) begin
         msg[0] = 8'h61;
         msg[1] = 8'h62;
         msg[2] = 8'h63;
      end
      push_expected(len);
      full = len / INPT_BYTE_DW;
      rem  = len % INPT_BYTE_DW;
      for (int b = 0; b < full; b++) begin
         w = '0;
         for (int k = 0; k < INPT_BYTE_DW; k++) w = (w << 8) | INPT_DW'(msg[b*INPT_BYTE_DW+k]);
         drive_beat(w, '1, (b == full - 1) && (rem == 0) && !zero_tail);
      end
      if (rem != 0 || zero_tail || len == 0) begin
         w = '0;
         m = '0;
         for (int k = 0; k < INPT_BYTE_DW; k++) begin
            if (k < rem) begin
               w = (w << 8) | INPT_DW'(msg[full*INPT_BYTE_DW+k]);
               m = m | INPT_BYTE_DW'(1 << (INPT_BYTE_DW - 1 - k));
            end else begin
               w = (w << 8) | (abc ? INPT_DW'(0) : INPT_DW'($urandom_range(0, 255)));
            end
         end
         drive_beat(w, m, 1'b1);
      end
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 5000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("drain_remaining_words", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_d"}, 64'(pad_otpt_d_o), 64'd0);
      check({tag, "_vld"}, 64'(pad_otpt_vld_o), 64'd0);
      check({tag, "_lst"}, 64'(pad_otpt_lst_o), 64'd0);
      check({tag, "_rdy"}, 64'(msg_inpt_rdy_o), 64'd0);
   endtask

   initial begin
      int len;
      bit zt;
      @(negedge clk);
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      send_msg(3, 1'b1, 1'b0);
      drain();
      send_msg(64, 1'b0, 1'b0);
      drain();
      send_msg(56, 1'b0, 1'b0);
      drain();
      send_msg(0, 1'b0, 1'b0);
      drain();

      // Mid-stream backpressure on an "abc" message.
      send_msg(3, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1 stall_n = 5;
      drain();

      // Reset while the padder is emitting zero fill.
      send_msg(3, 1'b1, 1'b0);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check_reset_outputs("mid_pad_reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_msg(3, 1'b1, 1'b0);
      drain();

      rand_ena = 1'b1;
      for (int n = 0; n < 40; n++) begin
         len = $urandom_range(0, 150);
         zt  = (len > 0 && len % INPT_BYTE_DW == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         send_msg(len, 1'b0, zt);
      end
      drain();
      rand_ena = 1'b0;
      repeat (20) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sm3_msg_padder.md
Name: sm3_msg_padder

Overview:
- Message-padding front end of the SM3 hash core (module instantiated as sm3_pad_core; sm3_pad_core_wrapper binds the same ports to the sm3_if bundle).
- Accepts a byte-granular message stream in INPT_DW-bit words.
- Emits the SM3/MD-style padded stream as INPT_DW-bit words: message, 0x80, zero fill, then the 64-bit big-endian message bit-length, so the total is a multiple of 512 bits.
- Feeds the message-expansion/compression stage.

Parameters:
- INPT_DW, 32, input/output word width in bits; legal values 32 or 64 (from sm3_cfg).
- INPT_BYTE_DW, INPT_DW/8, number of byte lanes.
- BLK_WORDS, 512/INPT_DW, words per 512-bit block (16 or 8).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- msg_inpt_d_i  in  INPT_DW  message word; byte 0 in bits [INPT_DW-1:INPT_DW-8] (big-endian).
- msg_inpt_vld_byte_i  in  INPT_BYTE_DW  byte-valid mask; MSB bit covers byte 0.
- msg_inpt_vld_i  in  1  input word valid.
- msg_inpt_lst_i  in  1  last word of message.
- pad_otpt_ena_i  in  1  downstream ready/enable.
- msg_inpt_rdy_o  out  1  padder accepts an input word.
- pad_otpt_d_o  out  INPT_DW  padded output word.
- pad_otpt_lst_o  out  1  last word of the final padded block.
- pad_otpt_vld_o  out  1  output word valid.

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE_MSG; word index 0; byte counter 0.
- Handshakes:
  - Input transfer: msg_inpt_vld_i && msg_inpt_rdy_o.
  - Output transfer: pad_otpt_vld_o && pad_otpt_ena_i.
- Output register loads when !pad_otpt_vld_o || pad_otpt_ena_i. It holds d/vld/lst stable otherwise.
- msg_inpt_rdy_o = (state==IDLE_MSG) && (!pad_otpt_vld_o || pad_otpt_ena_i). This path is combinational from pad_otpt_ena_i.
- Latency: an accepted input word appears on the output the next cycle.
- Byte mask rules:
  - Non-last beats must have all lanes valid.
  - The last beat mask is contiguous from the MSB: 1..1 0..0, and all-zero is allowed.
  - Other masks are unsupported; treat unlisted lanes as valid-contiguous count = popcount.
- Byte counter: 61-bit, adds popcount of the mask per accepted beat. Bit length = counter<<3, wraps modulo 2^64.
- Word index: counts output words 0..BLK_WORDS-1 and wraps per block.
- Length slot: the last 64 bits of a block.
  - INPT_DW=32: word index 14 = length[63:32], word index 15 = length[31:0].
  - INPT_DW=64: index 7 = length.
- States:
  - IDLE_MSG: pass input words through unchanged.
    - Last beat, partial (n<INPT_BYTE_DW valid bytes): output is the n valid bytes, then 0x80, then zeros. Next state is ZERO.
    - Last beat, full: output the word unchanged. Next state is PAD80.
  - PAD80: emit 0x80 followed by zero bytes as one word. Next state is ZERO.
  - ZERO: emit zero words until the next word index equals the first length-slot index. Then go to LEN.
    - If the 0x80-bearing word occupied a length-slot index, first zero-fill to the block end, then continue into a fresh block.
  - LEN: emit the length word(s). The final one asserts pad_otpt_lst_o. After it transfers, go to IDLE_MSG with the counter and index cleared.
- msg_inpt_rdy_o stays 0 outside IDLE_MSG.
- msg_inpt_vld_i during padding is ignored.
- Input words without vld do not advance the counter.
- rst_n low mid-message or mid-pad aborts immediately to the reset state; no partial output after release.

Decomposition:
- Package sm3_pkg:
  - INPT_DW, INPT_BYTE_DW, BLK_WORDS and length-slot index constants.
  - State enum {IDLE_MSG, PAD80, ZERO, LEN}.
- One combinational sub-module, sm3_pad_last_word: given a data word and mask, it returns the merged word with 0x80/zero fill and the valid-byte count.

Test Plan:
1. "abc" (INPT_DW=32): one beat d=0x61626300, mask=4'b1110, lst=1.
   -> 16 words: 0x61626380, 13×0x00000000, 0x00000000, 0x00000018.
   -> lst on the 16th word only.
2. 64-byte message, 16 full beats -> 32 words: the 16 input words, 0x80000000, 14 zeros, 0x00000200 (lst).
3. 56-byte message, 14 full beats -> 32 words: 14 inputs, 0x80000000, 0x00000000, 14 zeros, 0x00000000, 0x000001C0 (lst).
4. Empty message: one beat, mask=0, lst=1 -> 0x80000000, 15×0x00000000 (last = 0x00000000, lst).
5. Backpressure: pad_otpt_ena_i low for 5 cycles mid-stream.
   -> pad_otpt_d_o/vld/lst held constant and msg_inpt_rdy_o=0.
   -> resuming gives an output sequence identical to test 1.
6. Reset during the ZERO state -> all outputs 0 within the reset. Next "abc" message pads correctly, with length 0x18 (not accumulated).
